// File: rtl/dmem_arbiter_pkg.sv
// Shared constants, types and the access legality helper for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int WIDTH = 32;

    // RV32I load/store funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
        logic             we;
        logic [2:0]       funct3;
    } mem_req_t;

    // Legal funct3 for the direction, and natural alignment for halfword/word.
    // Store codes share encodings with LB/LH/LW, so only the load names appear.
    function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] alo);
        logic ok;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~alo[0];
            F3_LW:   ok = (alo == 2'b00);
            F3_LBU:  ok = ~we;
            F3_LHU:  ok = ~we & ~alo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant; combinational, one-hot output.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester always wins; on contention the port not granted last wins.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-cycle access sequencer for the single-ported data memory.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_addr0,
    input  logic [WIDTH-1:0] req_addr1,
    input  logic [WIDTH-1:0] req_wdata0,
    input  logic [WIDTH-1:0] req_wdata1,
    input  logic [1:0]       req_we,
    input  logic [2:0]       req_funct3_0,
    input  logic [2:0]       req_funct3_1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data,
    output logic             wr_en,
    output logic [2:0]       funct3,
    input  logic [WIDTH-1:0] mem_rdata
);

    state_t   state, state_nxt;
    logic     last;
    logic     owner;
    logic [1:0] gnt;
    mem_req_t req_sel, req_q;
    logic     acc;
    logic     sel_legal;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last),
        .gnt  (gnt)
    );

    // Present the granted port's request fields
    always_comb begin
        req_sel = '{addr: req_addr0, wdata: req_wdata0, we: req_we[0], funct3: req_funct3_0};
        if (gnt[1])
            req_sel = '{addr: req_addr1, wdata: req_wdata1, we: req_we[1], funct3: req_funct3_1};
    end

    assign acc       = (state == ST_IDLE) && (gnt != 2'b00);
    assign sel_legal = access_legal(req_sel.we, req_sel.funct3, req_sel.addr[1:0]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus handshake and memory outputs; memory is only driven in ISSUE,
    // so an async reset there drops wr_en before the memory's negedge.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        mem_addr  = '0;
        mem_data  = '0;
        wr_en     = 1'b0;
        funct3    = 3'b000;
        case (state)
            ST_IDLE: begin
                req_ready = gnt;
                if (acc) state_nxt = sel_legal ? ST_ISSUE : ST_RESP;
            end
            ST_ISSUE: begin
                mem_addr  = req_q.addr;
                mem_data  = req_q.wdata;
                funct3    = req_q.funct3;
                wr_en     = req_q.we;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the accepted request and build the response; illegal accesses
    // answer straight away, legal ones take the memory read at the end of ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (acc) begin
                req_q <= req_sel;
                owner <= gnt[1];
                last  <= gnt[1];
                if (!sel_legal) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
            if (state == ST_ISSUE) begin
                rsp_rdata <= req_q.we ? '0 : mem_rdata;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural byte-addressed data_mem.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [1:0]  req_we;
    logic [2:0]  req_funct3_0, req_funct3_1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr, mem_data;
    logic        wr_en;
    logic [2:0]  funct3;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        err;
    } stim_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    stim_t cur [0:1];
    stim_t stim_q [2][$];
    exp_t  exp_q  [2][$];
    int    gnt_log [$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, wr_cnt = 0, to_cnt = 0, bp_cnt = 0;
    logic done = 1'b0, fin = 1'b0;
    logic [1:0] prev_v = 2'b00, hs_prev = 2'b00;
    logic [31:0] held_d [0:1];
    logic        held_e [0:1];
    exp_t mon_e;

    assign req_addr0    = cur[0].addr;
    assign req_addr1    = cur[1].addr;
    assign req_wdata0   = cur[0].wdata;
    assign req_wdata1   = cur[1].wdata;
    assign req_we       = {cur[1].we, cur[0].we};
    assign req_funct3_0 = cur[0].f3;
    assign req_funct3_1 = cur[1].f3;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_we(req_we), .req_funct3_0(req_funct3_0), .req_funct3_1(req_funct3_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_data(mem_data), .wr_en(wr_en), .funct3(funct3),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // data_mem stand-in: negedge write, negedge-loaded read register
    logic [7:0]  mem [0:255];
    logic [31:0] rd_reg = 32'h0;
    assign mem_rdata = rd_reg;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hDEADBEEF;
        {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]} = 32'h11223344;
    end

    function automatic logic [31:0] mem_read(input logic [7:0] a, input logic [2:0] f3);
        logic [31:0] w;
        w = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (wr_en) begin
            mem[mem_addr[7:0]] <= mem_data[7:0];
            if (funct3 != 3'b000) mem[mem_addr[7:0] + 8'd1] <= mem_data[15:8];
            if (funct3 == 3'b010) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_data[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_data[31:24];
            end
        end
        rd_reg <= mem_read(mem_addr[7:0], funct3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each response handshake and checks protocol rules
    always @(negedge clk) begin
        if (rst) begin
            check("reset_ctrl", {req_ready, rsp_valid, rsp_err, wr_en, funct3}, 32'h0);
            check("reset_data", rsp_rdata | mem_addr | mem_data, 32'h0);
            prev_v  = 2'b00;
            hs_prev = 2'b00;
        end else begin
            if (hs_prev != 2'b00) check("idle_after_handshake", {30'h0, rsp_valid}, 32'h0);
            hs_prev = 2'b00;
            if ((req_valid & req_ready) != 2'b00) gnt_log.push_back(int'(req_ready[1]));
            check("ready_onehot", ($countones(req_ready) > 1) ? 32'h1 : 32'h0, 32'h0);
            if (rsp_valid != 2'b00) check("no_ready_outside_idle", {30'h0, req_ready}, 32'h0);
            if (wr_en) wr_cnt++;
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p]) begin
                    check($sformatf("outstanding_p%0d", p), exp_q[p].size(), 32'h1);
                    if (exp_q[p].size() > 0) begin
                        mon_e = exp_q[p][0];
                        if (!prev_v[p]) begin
                            check($sformatf("latency_p%0d", p), cyc + 1 - mon_e.acc, mon_e.lat);
                        end else begin
                            check($sformatf("hold_rdata_p%0d", p), rsp_rdata, held_d[p]);
                            check($sformatf("hold_err_p%0d", p), {31'h0, rsp_err}, {31'h0, held_e[p]});
                        end
                        held_d[p] = rsp_rdata;
                        held_e[p] = rsp_err;
                        if (rsp_ready[p]) begin
                            check($sformatf("rdata_p%0d", p), rsp_rdata, mon_e.rdata);
                            check($sformatf("err_p%0d", p), {31'h0, rsp_err}, {31'h0, mon_e.err});
                            void'(exp_q[p].pop_front());
                            hs_prev[p] = 1'b1;
                        end
                    end
                end
            end
            prev_v = rsp_valid;
        end
        if (done && !fin) begin
            check("timeouts", to_cnt, 32'h0);
            check("wr_en_cycles", wr_cnt, 32'h1);
            check("leftover_p0", exp_q[0].size(), 32'h0);
            check("leftover_p1", exp_q[1].size(), 32'h0);
            check("grant_log_len", (gnt_log.size() >= 4) ? 32'h1 : 32'h0, 32'h1);
            for (int i = 0; i < 4; i++)
                if (gnt_log.size() > i) check($sformatf("grant_order_%0d", i), gnt_log[i], i % 2);
            fin = 1'b1;
        end
    end

    task automatic add(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic we, input logic [2:0] f3, input logic [31:0] rdata,
                       input logic err);
        stim_t s;
        s = '{addr: addr, wdata: wdata, we: we, f3: f3, rdata: rdata, err: err};
        stim_q[p].push_back(s);
    endtask

    // Driver: holds each port's request until accepted, pushes the expected response
    task automatic run_phase(input int budget);
        logic [1:0] acc = 2'b00;
        int  n = 0;
        bit  busy;
        exp_t e;
        do begin
            @(posedge clk); #1;
            if (bp_cnt == 0) rsp_ready[0] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin req_valid[p] = 1'b0; acc[p] = 1'b0; end
                if (!req_valid[p] && stim_q[p].size() > 0) begin
                    cur[p] = stim_q[p].pop_front();
                    req_valid[p] = 1'b1;
                end
            end
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    acc[p] = 1'b1;
                    e = '{rdata: cur[p].rdata, err: cur[p].err,
                          lat: cur[p].err ? 1 : 2, acc: cyc + 1};
                    exp_q[p].push_back(e);
                end
            end
            if (bp_cnt > 0 && rsp_valid[0] && !rsp_ready[0]) bp_cnt--;
            n++;
            busy = (stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size() > 0)
                   || (req_valid != 2'b00);
        end while (busy && n < budget);
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) if (acc[p]) req_valid[p] = 1'b0;
        if (busy) to_cnt++;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) cur[p] = '{default: '0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // contention straight out of reset: port 0 first, then alternating
        add(0, 32'h10, 0, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0);
        add(0, 32'h10, 0, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0);
        add(1, 32'h80, 0, 1'b0, 3'b010, 32'h11223344, 1'b0);
        add(1, 32'h80, 0, 1'b0, 3'b010, 32'h11223344, 1'b0);
        run_phase(60);

        // single load
        add(0, 32'h10, 0, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0);
        run_phase(20);

        // misaligned / illegal funct3
        add(0, 32'h13, 0, 1'b0, 3'b010, 32'h0, 1'b1);
        add(0, 32'h21, 0, 1'b0, 3'b001, 32'h0, 1'b1);
        add(1, 32'h40, 32'hCAFEF00D, 1'b1, 3'b100, 32'h0, 1'b1);
        add(1, 32'h23, 0, 1'b0, 3'b101, 32'h0, 1'b1);
        add(0, 32'h00, 0, 1'b0, 3'b011, 32'h0, 1'b1);
        run_phase(60);

        // byte store, then loads of it and of sign/zero-extended halfwords
        add(1, 32'h41, 32'h000000A5, 1'b1, 3'b000, 32'h0, 1'b0);
        run_phase(20);
        add(0, 32'h41, 0, 1'b0, 3'b100, 32'h000000A5, 1'b0);
        add(0, 32'h41, 0, 1'b0, 3'b000, 32'hFFFFFFA5, 1'b0);
        add(0, 32'h40, 0, 1'b0, 3'b010, 32'h0000A500, 1'b0);
        add(0, 32'h12, 0, 1'b0, 3'b101, 32'h0000DEAD, 1'b0);
        add(0, 32'h12, 0, 1'b0, 3'b001, 32'hFFFFDEAD, 1'b0);
        run_phase(60);

        // response backpressure on port 0 for 5 cycles
        rsp_ready = 2'b10;
        bp_cnt = 5;
        add(0, 32'h10, 0, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0);
        run_phase(30);
        rsp_ready = 2'b11;
        bp_cnt = 0;

        // reset while the SW is in ISSUE, ahead of the memory negedge
        @(posedge clk); #1;
        cur[0] = '{addr: 32'h80, wdata: 32'h55AA55AA, we: 1'b1, f3: 3'b010, rdata: 0, err: 0};
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // word 0x80 must still hold its old contents
        add(0, 32'h80, 0, 1'b0, 3'b010, 32'h11223344, 1'b0);
        run_phase(20);

        done = 1'b1;
        for (int i = 0; i < 10 && !fin; i++) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the core data memory. Shares the single-ported `data_mem` (negedge-write, one-word read register) between port 0, the core load/store unit, and port 1, the program loader/debug port. Uses round-robin grant and screens each request for alignment and funct3 legality. Drives the memory for exactly one cycle, then returns a registered response per port with valid/ready handshakes.

## Interface
- `WIDTH`, 32, data/address width (from `rv_defs.vh`)
- `clk`  in  1  system clock; memory side samples on negedge, this block on posedge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid[1:0]`  in  2  per-port request valid
- `req_ready[1:0]`  out  2  per-port request accept
- `req_addr0`, `req_addr1`  in  WIDTH  byte address
- `req_wdata0`, `req_wdata1`  in  WIDTH  store data, LSB-aligned
- `req_we[1:0]`  in  2  1 = store, 0 = load
- `req_funct3_0`, `req_funct3_1`  in  3  RV32I load/store funct3
- `rsp_valid[1:0]`  out  2  per-port response valid
- `rsp_ready[1:0]`  in  2  per-port response accept
- `rsp_rdata`  out  WIDTH  load result (0 for stores and errors), shared by both ports
- `rsp_err`  out  1  access rejected (misaligned or illegal funct3)
- `mem_addr`  out  WIDTH  to `data_mem`
- `mem_data`  out  WIDTH  to `data_mem`
- `wr_en`  out  1  to `data_mem`
- `funct3`  out  3  to `data_mem`
- `mem_rdata`  in  WIDTH  from `data_mem` `data_out`

## Operation
- **FSM states**
  - IDLE: `req_ready` = grant vector; at most one bit set.
  - ISSUE: memory signals driven from registered request.
  - RESP: `rsp_valid[owner]` = 1.
- **Arbitration**
  - Only one valid: that port wins.
  - Both valid: the port not granted last wins.
  - `last` resets to 1, so port 0 wins the first contention.
- **Acceptance:** on `req_valid[p] & req_ready[p]` at posedge, capture addr/wdata/we/funct3, record owner = p, update `last` = p.
- **Legality check at acceptance**
  - Loads are legal for 000/001/010/100/101. Stores are legal for 000/001/010.
  - Halfword (001/101) requires addr[0] = 0. Word (010) requires addr[1:0] = 0.
  - Illegal access: IDLE→RESP directly. `rsp_err` = 1, `rsp_rdata` = 0, memory never driven (`wr_en` stays 0).
- **Legal access:** IDLE→ISSUE→RESP.
  - ISSUE drives `mem_addr`, `mem_data`, `funct3`, and `wr_en` = we.
  - At the posedge ending ISSUE, `rsp_rdata` ← `mem_rdata` for loads, 0 for stores. `rsp_err` ← 0.
- **RESP:** hold `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready[owner]` = 1, then go to IDLE. The non-owner port's `rsp_ready` is ignored.
- **Idle memory outputs:** outside ISSUE, `wr_en` = 0 and `mem_addr`/`mem_data`/`funct3` = 0.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last` = 1. Reset is asynchronous.
  - Reset during ISSUE before the negedge drops `wr_en` immediately: the store is not committed.
  - Reset during RESP discards the response. The requester must re-issue.
- **Latency:**
  - Legal access: accept at edge N, `rsp_valid` high from edge N+2.
  - Illegal access: `rsp_valid` high from edge N+1.
- **Throughput:** one legal access per 3 cycles with immediate `rsp_ready`. No request is accepted while in ISSUE or RESP.
- **Memory read path:** the memory read register loads at the ISSUE negedge, and `mem_rdata` is settled by the next posedge. A load after a store to the same word sees the new data.
- **Request stability:** requests must hold all fields while `req_valid` is high and not yet accepted. `req_valid` may drop without acceptance.

## Structure
- funct3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW) and the FSM state encoding go in `rv_defs.vh` as shared constants.
- One sub-module: `rr_arb2`, a 2-requester round-robin grant (inputs `req[1:0]`, `last`; output one-hot `gnt[1:0]`, combinational).

## Test plan
- **Single load:** port 0 LW 0x10, memory word 0x10 = 0xDEADBEEF, `rsp_ready` = 1 → `rsp_valid[0]` at edge N+2, `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0.
- **Contention:** both ports request continuously → grants alternate 0,1,0,1. Each port's response returns only on its own `rsp_valid` bit.
- **Misaligned/illegal:** LW 0x13, LH 0x21, SW with funct3 = 100 → `rsp_err` = 1, `rsp_rdata` = 0, `rsp_valid` at N+1, `wr_en` never asserted.
- **Byte store then load:** port 1 SB 0xA5 to 0x41, then port 0 LBU 0x41 → 0x000000A5; LB 0x41 → 0xFFFFFFA5.
- **Backpressure:** `rsp_ready[0]` held 0 for 5 cycles → response fields stable, `req_ready` = 00 throughout. Release → IDLE next edge.
- **Reset mid-store:** assert `rst` in ISSUE before the negedge of an SW 0x55AA55AA to 0x80 → `wr_en` falls immediately, word 0x80 unchanged, all outputs 0.
